// File: rtl/logical_compare_pkg.sv
// Shared types for the digit-serial logical comparator: relational opcodes,
// FSM states and the helper that maps the final gt/eq flags to the result bit.
package logical_compare_pkg;

    // Relational operation selector. Codes 6 and 7 are reserved and yield c=0.
    typedef enum logic [2:0] {
        EQ = 3'd0,
        NE = 3'd1,
        LT = 3'd2,
        LE = 3'd3,
        GT = 3'd4,
        GE = 3'd5
    } cmp_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Result of (a op b) given the final magnitude decision.
    function automatic logic eval_op(input logic [2:0] op, input logic gt, input logic eq);
        logic lt;
        lt = ~gt & ~eq;
        case (op)
            EQ:      eval_op = eq;
            NE:      eval_op = ~eq;
            LT:      eval_op = lt;
            LE:      eval_op = lt | eq;
            GT:      eval_op = gt;
            GE:      eval_op = gt | eq;
            default: eval_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/digit_serial_logical_compare_if.sv
// Handshake and data bundle of the digit-serial comparator.
// master: the producer/consumer side; slave: the comparator itself.
interface digit_serial_logical_compare_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic         c;
    logic         gt;
    logic         eq;

    modport master (
        output in_valid, a, b, op, is_signed, out_ready,
        input  in_ready, out_valid, c, gt, eq
    );

    modport slave (
        input  in_valid, a, b, op, is_signed, out_ready,
        output in_ready, out_valid, c, gt, eq
    );
endinterface

// File: rtl/logical_digit_cmp.sv
// Combinational W-bit digit comparator. Inverting the MSB of both digits turns
// the unsigned compare into a two's-complement compare for the top digit.
module logical_digit_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         invert_msb,
    output logic         dgt,
    output logic         deq
);

    logic [W-1:0] xm;
    logic [W-1:0] ym;

    // Optional sign-bit flip, then plain unsigned magnitude compare.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        xm         = x;
        ym         = y;
        xm[W-1]    = x[W-1] ^ invert_msb;
        ym[W-1]    = y[W-1] ^ invert_msb;
        dgt        = (xm > ym);
        deq        = (xm == ym);
    end

endmodule

// File: rtl/digit_serial_logical_compare.sv
// Digit-serial relational comparator: N-bit operands compared MSB-first,
// one W-bit digit per clock, with valid/ready on both sides.
// Build option: LOGICAL_COMPARE_EARLY_EXIT_EN -- finish on the first
// differing digit instead of always spending D compare cycles.
module digit_serial_logical_compare
    import logical_compare_pkg::*;
#(
    parameter int N = 32,
    parameter int W = 8
) (
    input logic                          clk,
    input logic                          rst_n,
    digit_serial_logical_compare_if.slave bus
);

    localparam int D     = N / W;
    localparam int CNT_W = (D > 1) ? $clog2(D) : 1;

`ifdef LOGICAL_COMPARE_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               dec_q, dec_d;     // a differing digit has been seen
    logic               dgt_q, dgt_d;     // direction of that first difference
    logic               c_q, c_d;
    logic               gt_q, gt_d;
    logic               eq_q, eq_d;

    // Operands are held left-aligned; the current digit is always the top W bits.
    logic [N-1:0]       a_q, b_q;
    logic [2:0]         op_q;
    logic               sgn_q;

    logic               accept;
    logic               last_digit;
    logic               dig_gt, dig_eq;
    logic               now_dec, now_gt;
    logic               finish;

    assign accept     = bus.in_valid && (state_q == IDLE);
    assign last_digit = (cnt_q == CNT_W'(D - 1));

    logical_digit_cmp #(.W(W)) u_digit (
        .x          (a_q[N-1 -: W]),
        .y          (b_q[N-1 -: W]),
        .invert_msb (sgn_q && (cnt_q == '0)),
        .dgt        (dig_gt),
        .deq        (dig_eq)
    );

    // The first differing digit decides; later digits only matter while undecided.
    assign now_dec = dec_q | ~dig_eq;
    assign now_gt  = dec_q ? dgt_q : dig_gt;
    assign finish  = last_digit || (EARLY_EXIT && !dig_eq);

    // Next-state and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dec_d   = dec_q;
        dgt_d   = dgt_q;
        c_d     = c_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COMPARE;
                    cnt_d   = '0;
                    dec_d   = 1'b0;
                    dgt_d   = 1'b0;
                    c_d     = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b0;
                end
            end
            COMPARE: begin
                cnt_d = cnt_q + CNT_W'(1);
                dec_d = now_dec;
                dgt_d = now_gt;
                if (finish) begin
                    state_d = DONE;
                    gt_d    = now_gt;
                    eq_d    = ~now_dec;
                    c_d     = eval_op(op_q, now_gt, ~now_dec);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state with synchronous active-low reset; discards any in-flight work.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dec_q   <= 1'b0;
            dgt_q   <= 1'b0;
            c_q     <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dec_q   <= dec_d;
            dgt_q   <= dgt_d;
            c_q     <= c_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    // Operand capture and per-cycle digit advance.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; they are always loaded on accept before use.
        if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            op_q  <= bus.op;
            sgn_q <= bus.is_signed;
        end else if (state_q == COMPARE) begin
            a_q   <= a_q << W;
            b_q   <= b_q << W;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.c         = c_q;
    assign bus.gt        = gt_q;
    assign bus.eq        = eq_q;

endmodule

// File: tb/tb_digit_serial_logical_compare.sv
// Directed bench for digit_serial_logical_compare with N=8, W=2 (D=4).
// Expected latencies follow LOGICAL_COMPARE_EARLY_EXIT_EN when it is defined.
module tb_digit_serial_logical_compare;

    localparam int N = 8;
    localparam int W = 2;
    localparam int D = N / W;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    digit_serial_logical_compare_if #(.N(N)) bus ();

    digit_serial_logical_compare #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // k = index of the first differing digit (D when operands are equal).
    function automatic int exp_lat(input int k);
`ifdef LOGICAL_COMPARE_EARLY_EXIT_EN
        return (k < D) ? k + 1 : D;
`else
        return D;
`endif
    endfunction

    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic sgn, input int k,
                       input logic ec, input logic egt, input logic eeq, input int hold);
        int lat;
        @(negedge clk);
        bus.a         = a;
        bus.b         = b;
        bus.op        = op;
        bus.is_signed = sgn;
        bus.in_valid  = 1'b1;
        check({tag, " in_ready idle"}, bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat(k));
        check({tag, " c"}, bus.c, ec);
        check({tag, " gt"}, bus.gt, egt);
        check({tag, " eq"}, bus.eq, eeq);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold out_valid"}, bus.out_valid, 1);
            check({tag, " hold in_ready"}, bus.in_ready, 0);
            check({tag, " hold flags"}, {bus.c, bus.gt, bus.eq}, {ec, egt, eeq});
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        check({tag, " accept-cycle in_ready"}, bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, " consumed out_valid"}, bus.out_valid, 0);
        check({tag, " in_ready after consume"}, bus.in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit stale;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", bus.in_ready, 1);
        check("reset out_valid", bus.out_valid, 0);
        check("reset flags", {bus.c, bus.gt, bus.eq}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        //   tag          a      b      op    sgn k  c  gt eq hold
        run("ge_uns",   8'h80, 8'h7F, 3'd5, 1'b0, 0, 1, 1, 0, 0);
        run("lt_sgn",   8'h80, 8'h01, 3'd2, 1'b1, 0, 1, 0, 0, 0);
        run("lt_uns",   8'h80, 8'h01, 3'd2, 1'b0, 0, 0, 1, 0, 0);
        run("eq_same",  8'hA5, 8'hA5, 3'd0, 1'b0, 4, 1, 0, 1, 0);
        run("gt_c0_40", 8'hC0, 8'h40, 3'd4, 1'b0, 0, 1, 1, 0, 0);
        run("rsv_op7",  8'hC0, 8'h40, 3'd7, 1'b0, 0, 0, 1, 0, 0);
        run("ne_last",  8'h12, 8'h13, 3'd1, 1'b0, 3, 1, 0, 0, 0);
        run("le_sgn",   8'hFF, 8'hFE, 3'd3, 1'b1, 3, 0, 1, 0, 0);
        run("ge_sgn",   8'h7F, 8'h80, 3'd5, 1'b1, 0, 1, 1, 0, 0);
        run("le_eq",    8'h3C, 8'h3C, 3'd3, 1'b0, 4, 1, 0, 1, 0);
        run("backpres", 8'h21, 8'h24, 3'd2, 1'b0, 2, 1, 0, 0, 10);

        // Reset two edges after acceptance: nothing from that compare may surface.
        @(negedge clk);
        bus.a        = 8'h01;
        bus.b        = 8'h02;
        bus.op       = 3'd2;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midreset in_ready", bus.in_ready, 1);
        check("midreset out_valid", bus.out_valid, 0);
        check("midreset flags", {bus.c, bus.gt, bus.eq}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < D + 4; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale = 1'b1;
        end
        check("no stale result", stale, 0);

        run("recover", 8'h55, 8'h54, 3'd4, 1'b0, 3, 1, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
